// File: rtl/axi_master_arbiter_w.sv
// Two-master AXI write-channel arbiter: round-robin grant held for a whole
// AW / W-burst / B transaction; granted master is forwarded on the s_* bus.
module axi_master_arbiter_w #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned USER_WIDTH = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // master 0
  input  logic [ID_WIDTH-1:0]     m0_AWID,
  input  logic [ADDR_WIDTH-1:0]   m0_AWADDR,
  input  logic [7:0]              m0_AWLEN,
  input  logic [2:0]              m0_AWSIZE,
  input  logic [1:0]              m0_AWBURST,
  input  logic                    m0_AWVALID,
  output logic                    m0_AWREADY,
  input  logic [DATA_WIDTH-1:0]   m0_WDATA,
  input  logic [DATA_WIDTH/8-1:0] m0_WSTRB,
  input  logic                    m0_WLAST,
  input  logic                    m0_WVALID,
  output logic                    m0_WREADY,
  output logic [ID_WIDTH-1:0]     m0_BID,
  output logic [1:0]              m0_BRESP,
  output logic [USER_WIDTH-1:0]   m0_BUSER,
  output logic                    m0_BVALID,
  input  logic                    m0_BREADY,
  // master 1
  input  logic [ID_WIDTH-1:0]     m1_AWID,
  input  logic [ADDR_WIDTH-1:0]   m1_AWADDR,
  input  logic [7:0]              m1_AWLEN,
  input  logic [2:0]              m1_AWSIZE,
  input  logic [1:0]              m1_AWBURST,
  input  logic                    m1_AWVALID,
  output logic                    m1_AWREADY,
  input  logic [DATA_WIDTH-1:0]   m1_WDATA,
  input  logic [DATA_WIDTH/8-1:0] m1_WSTRB,
  input  logic                    m1_WLAST,
  input  logic                    m1_WVALID,
  output logic                    m1_WREADY,
  output logic [ID_WIDTH-1:0]     m1_BID,
  output logic [1:0]              m1_BRESP,
  output logic [USER_WIDTH-1:0]   m1_BUSER,
  output logic                    m1_BVALID,
  input  logic                    m1_BREADY,
  // toward the slave mux
  output logic [ID_WIDTH-1:0]     s_AWID,
  output logic [ADDR_WIDTH-1:0]   s_AWADDR,
  output logic [7:0]              s_AWLEN,
  output logic [2:0]              s_AWSIZE,
  output logic [1:0]              s_AWBURST,
  output logic                    s_AWVALID,
  input  logic                    s_AWREADY,
  output logic [DATA_WIDTH-1:0]   s_WDATA,
  output logic [DATA_WIDTH/8-1:0] s_WSTRB,
  output logic                    s_WLAST,
  output logic                    s_WVALID,
  input  logic                    s_WREADY,
  input  logic [ID_WIDTH-1:0]     s_BID,
  input  logic [1:0]              s_BRESP,
  input  logic [USER_WIDTH-1:0]   s_BUSER,
  input  logic                    s_BVALID,
  output logic                    s_BREADY
);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;
  logic   last, last_nxt;

  // State, grant and last-served registers; reset favours m0 on the first tie.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= ST_IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, then follow AW -> W (until WLAST) -> B.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (m0_AWVALID || m1_AWVALID) begin
          state_nxt = ST_AW;
          if (m0_AWVALID && m1_AWVALID) grant_nxt = ~last;
          else                          grant_nxt = m1_AWVALID;
        end
      end
      ST_AW: if (s_AWVALID && s_AWREADY)            state_nxt = ST_W;
      ST_W:  if (s_WVALID && s_WREADY && s_WLAST)   state_nxt = ST_B;
      ST_B: begin
        if (s_BVALID && s_BREADY) begin
          last_nxt  = grant;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output routing: only the active channel of the granted master is connected.
  always_comb begin
    s_AWID     = '0;
    s_AWADDR   = '0;
    s_AWLEN    = '0;
    s_AWSIZE   = '0;
    s_AWBURST  = '0;
    s_AWVALID  = 1'b0;
    s_WDATA    = '0;
    s_WSTRB    = '0;
    s_WLAST    = 1'b0;
    s_WVALID   = 1'b0;
    s_BREADY   = 1'b0;
    m0_AWREADY = 1'b0;
    m0_WREADY  = 1'b0;
    m0_BID     = '0;
    m0_BRESP   = '0;
    m0_BUSER   = '0;
    m0_BVALID  = 1'b0;
    m1_AWREADY = 1'b0;
    m1_WREADY  = 1'b0;
    m1_BID     = '0;
    m1_BRESP   = '0;
    m1_BUSER   = '0;
    m1_BVALID  = 1'b0;
    case (state)
      ST_AW: begin
        if (grant) begin
          s_AWID     = m1_AWID;
          s_AWADDR   = m1_AWADDR;
          s_AWLEN    = m1_AWLEN;
          s_AWSIZE   = m1_AWSIZE;
          s_AWBURST  = m1_AWBURST;
          s_AWVALID  = m1_AWVALID;
          m1_AWREADY = s_AWREADY;
        end else begin
          s_AWID     = m0_AWID;
          s_AWADDR   = m0_AWADDR;
          s_AWLEN    = m0_AWLEN;
          s_AWSIZE   = m0_AWSIZE;
          s_AWBURST  = m0_AWBURST;
          s_AWVALID  = m0_AWVALID;
          m0_AWREADY = s_AWREADY;
        end
      end
      ST_W: begin
        if (grant) begin
          s_WDATA   = m1_WDATA;
          s_WSTRB   = m1_WSTRB;
          s_WLAST   = m1_WLAST;
          s_WVALID  = m1_WVALID;
          m1_WREADY = s_WREADY;
        end else begin
          s_WDATA   = m0_WDATA;
          s_WSTRB   = m0_WSTRB;
          s_WLAST   = m0_WLAST;
          s_WVALID  = m0_WVALID;
          m0_WREADY = s_WREADY;
        end
      end
      ST_B: begin
        if (grant) begin
          m1_BID    = s_BID;
          m1_BRESP  = s_BRESP;
          m1_BUSER  = s_BUSER;
          m1_BVALID = s_BVALID;
          s_BREADY  = m1_BREADY;
        end else begin
          m0_BID    = s_BID;
          m0_BRESP  = s_BRESP;
          m0_BUSER  = s_BUSER;
          m0_BVALID = s_BVALID;
          s_BREADY  = m0_BREADY;
        end
      end
      default: ;
    endcase
  end

endmodule
